// File: rtl/quad_decoder_pkg.sv
// Shared constants and transition helpers for the quadrature decoder.
package quad_pkg;

  // Count-resolution selector values (3 behaves like x1)
  localparam logic [1:0] MODE_X4 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X1 = 2'd2;

  // Phase encodings as {A,B}
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_t;

  // Result of classifying one phase change
  typedef struct packed {
    logic valid;    // single-bit move
    logic illegal;  // both bits changed
    logic dir;      // 1 = forward/up, 0 = reverse/down
  } trans_t;

  // Next phase in the forward (A leads B) sequence
  function automatic logic [1:0] phase_fwd(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  // Classify a move from prev to next
  function automatic trans_t quad_lookup(input logic [1:0] prev, input logic [1:0] next);
    trans_t t;
    t = '0;
    if (next == phase_fwd(prev)) begin
      t.valid = 1'b1;
      t.dir   = 1'b1;
    end else if (prev == phase_fwd(next)) begin
      t.valid = 1'b1;
      t.dir   = 1'b0;
    end else if ((prev ^ next) == 2'b11) begin
      t.illegal = 1'b1;
    end
    return t;
  endfunction

  // Whether a legal move produces a step at the given resolution
  function automatic logic mode_counts(input logic [1:0] mode, input logic [1:0] prev,
                                       input logic [1:0] next);
    case (mode)
      MODE_X4: return 1'b1;
      MODE_X2: return prev[1] != next[1];
      default: return ((prev == PH_00) && (next == PH_10)) ||
                      ((prev == PH_10) && (next == PH_00));
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Multi-bit synchroniser followed by a stability filter. A new value is only
// accepted after it has been seen unchanged for FILTER_LEN synchronised cycles.
// The first accepted value after reset primes the output without flagging a change.
module quad_input_filter #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_filt,
  output logic             o_change
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [SYNC_STAGES-1:0]            r_fill;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_filt;
  logic [CNT_W-1:0]                  r_cnt;
  logic                              r_primed;
  logic                              r_change;

  logic [WIDTH-1:0] w_s;
  logic             w_ready;
  logic             w_want;

  assign w_s     = r_sync[SYNC_STAGES-1];
  // r_fill marks when the chain holds sampled pins rather than reset zeros,
  // so priming never locks onto the flops' reset value.
  assign w_ready = r_fill[SYNC_STAGES-1];
  assign w_want  = r_primed ? (w_s != r_filt) : w_ready;

  // Synchroniser shift chain plus fill marker
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Stability counter, qualified-value latch and priming
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev   <= '0;
      r_filt   <= '0;
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_prev   <= w_s;
      r_change <= 1'b0;
      if ((w_s != r_prev) || !w_want) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_filt   <= w_s;
        r_primed <= 1'b1;
        r_change <= r_primed;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt   = r_filt;
  assign o_change = r_change;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phase tracking, resolution-qualified step
// pulses with direction, and illegal-jump error reporting.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic [1:0] mode,
  input  logic       err_clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic       err_sticky
);

  logic [1:0] w_filt;
  logic       w_change;
  trans_t     w_tr;
  logic       w_count;

  logic [1:0] r_phase;
  logic       r_step;
  logic       r_up_down;
  logic       r_err;
  logic       r_err_sticky;

  quad_input_filter #(
    .WIDTH      (2),
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .i_raw   ({quad_a, quad_b}),
    .o_filt  (w_filt),
    .o_change(w_change)
  );

  // r_phase lags the filtered value by one cycle, so (r_phase, w_filt) is the move
  assign w_tr    = quad_lookup(r_phase, w_filt);
  assign w_count = mode_counts(mode, r_phase, w_filt);

  // Phase tracking, step/direction/error generation and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= PH_00;
      r_step       <= 1'b0;
      r_up_down    <= 1'b1;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_phase <= w_filt;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
      if (w_change) begin
        if (w_tr.illegal) begin
          r_err <= 1'b1;
        end else if (w_tr.valid) begin
          r_up_down <= w_tr.dir;
          r_step    <= w_count;
        end
      end
      // A clear arriving while err is still high is ignored so the set wins
      if (w_change && w_tr.illegal) begin
        r_err_sticky <= 1'b1;
      end else if (err_clr && !r_err) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign step       = r_step;
  assign up_down    = r_up_down;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed, table-driven bench for quad_decoder with default parameters.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       quad_a;
  logic       quad_b;
  logic [1:0] mode;
  logic       err_clr;
  logic       step;
  logic       up_down;
  logic       err;
  logic       err_sticky;

  quad_decoder #(
    .SYNC_STAGES(2),
    .FILTER_LEN (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .mode      (mode),
    .err_clr   (err_clr),
    .step      (step),
    .up_down   (up_down),
    .err       (err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Expected cycles from pin change (set just after edge k) to step/err visible
  localparam int LAT = 7;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Running totals sampled mid-cycle
  int tot_steps = 0;
  int tot_ups   = 0;
  int tot_errs  = 0;
  int last_step_cyc = -1;
  always @(negedge clk) begin
    if (step === 1'b1) begin
      tot_steps     = tot_steps + 1;
      last_step_cyc = cyc;
      if (up_down === 1'b1) tot_ups = tot_ups + 1;
    end
    if (err === 1'b1) tot_errs = tot_errs + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] ab;
    logic [1:0] md;
    int         hold;
    int         e_steps;
    int         e_ups;
    logic       e_ud;
    int         e_errs;
    logic       e_sticky;
    bit         lat;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] ab, input logic [1:0] md, input int hold,
                              input int s, input int u, input logic ud, input int e,
                              input logic st, input bit lat);
    vec_t v;
    v.ab = ab; v.md = md; v.hold = hold; v.e_steps = s; v.e_ups = u;
    v.e_ud = ud; v.e_errs = e; v.e_sticky = st; v.lat = lat;
    return v;
  endfunction

  // Apply one pin level, hold it, then compare the window's activity
  task automatic run_vec(input vec_t v, input string tag);
    int k, s0, u0, e0;
    s0 = tot_steps; u0 = tot_ups; e0 = tot_errs;
    quad_a = v.ab[1];
    quad_b = v.ab[0];
    mode   = v.md;
    k      = cyc;
    repeat (v.hold) @(posedge clk);
    #1;
    chk({tag, " steps"},   tot_steps - s0, v.e_steps);
    chk({tag, " ups"},     tot_ups - u0,   v.e_ups);
    chk({tag, " up_down"}, {31'd0, up_down},    {31'd0, v.e_ud});
    chk({tag, " errs"},    tot_errs - e0,  v.e_errs);
    chk({tag, " sticky"},  {31'd0, err_sticky}, {31'd0, v.e_sticky});
    if (v.lat && v.e_steps == 1) chk({tag, " latency"}, last_step_cyc - k, LAT);
    $display("%s ab=%b mode=%0d steps=%0d ups=%0d errs=%0d up_down=%b sticky=%b",
             tag, v.ab, v.md, tot_steps - s0, tot_ups - u0, tot_errs - e0, up_down, err_sticky);
  endtask

  vec_t tbl[$];

  initial begin
    int k, e0, s0;
    // Test 1: x4 forward
    tbl.push_back(mk(2'b10, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b11, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b01, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b00, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
    // Test 2: x4 reverse, then forward again
    tbl.push_back(mk(2'b01, 2'd0, 10, 1, 0, 1'b0, 0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b11, 2'd0, 10, 1, 0, 1'b0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, 2'd0, 10, 1, 0, 1'b0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'd0, 10, 1, 0, 1'b0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b11, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b01, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b0));
    // Test 3: x1 three forward cycles, then across the boundary and back
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(2'b10, 2'd2, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
      tbl.push_back(mk(2'b11, 2'd2, 10, 0, 0, 1'b1, 0, 1'b0, 1'b0));
      tbl.push_back(mk(2'b01, 2'd2, 10, 0, 0, 1'b1, 0, 1'b0, 1'b0));
      tbl.push_back(mk(2'b00, 2'd2, 10, 0, 0, 1'b1, 0, 1'b0, 1'b0));
    end
    tbl.push_back(mk(2'b10, 2'd2, 10, 1, 1, 1'b1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'd2, 10, 1, 0, 1'b0, 0, 1'b0, 1'b0));
    // Test 3b: x2 three forward cycles (two steps each)
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(2'b10, 2'd1, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
      tbl.push_back(mk(2'b11, 2'd1, 10, 0, 0, 1'b1, 0, 1'b0, 1'b0));
      tbl.push_back(mk(2'b01, 2'd1, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
      tbl.push_back(mk(2'b00, 2'd1, 10, 0, 0, 1'b1, 0, 1'b0, 1'b0));
    end
    // Test 4: 2-cycle glitch absorbed, then a held pulse counts
    tbl.push_back(mk(2'b10, 2'd0, 2,  0, 0, 1'b1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'd0, 10, 0, 0, 1'b1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b00, 2'd0, 10, 1, 0, 1'b0, 0, 1'b0, 1'b1));
    // Mode 3 behaves like x1
    tbl.push_back(mk(2'b10, 2'd3, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1));
    tbl.push_back(mk(2'b11, 2'd3, 10, 0, 0, 1'b1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, 2'd3, 10, 0, 0, 1'b0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, 2'd3, 10, 1, 0, 1'b0, 0, 1'b0, 1'b0));
    // Test 5: illegal jump 00->11, up_down held at 0
    tbl.push_back(mk(2'b11, 2'd0, 10, 0, 0, 1'b0, 1, 1'b1, 1'b0));

    // Reset with pins at 00, x4
    reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0; mode = 2'd0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset step",       {31'd0, step},       32'd0);
    chk("reset up_down",    {31'd0, up_down},    32'd1);
    chk("reset err",        {31'd0, err},        32'd0);
    chk("reset err_sticky", {31'd0, err_sticky}, 32'd0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("prime steps", tot_steps, 0);
    chk("prime errs",  tot_errs,  0);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // err_clr clears the sticky flag
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr sticky", {31'd0, err_sticky}, 32'd0);
    $display("clr err_sticky=%b", err_sticky);

    // Illegal 11->00 with err_clr asserted during the err pulse: set wins
    e0 = tot_errs; s0 = tot_steps;
    quad_a = 1'b0; quad_b = 1'b0;
    k = cyc;
    repeat (LAT) @(posedge clk);
    #1;
    chk("collide err pulse", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("collide err end",   {31'd0, err},        32'd0);
    chk("collide sticky",    {31'd0, err_sticky}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("collide errs",  tot_errs - e0,  1);
    chk("collide steps", tot_steps - s0, 0);
    $display("collide err_pulses=%0d sticky=%b after %0d cycles", tot_errs - e0, err_sticky, cyc - k);

    // Phase adopted 00 after the error: forward moves step up, sticky remains
    run_vec(mk(2'b10, 2'd0, 10, 1, 1, 1'b1, 0, 1'b1, 1'b1), "adopt10");
    run_vec(mk(2'b11, 2'd0, 10, 1, 1, 1'b1, 0, 1'b1, 1'b1), "adopt11");

    // Test 6: reset mid-operation with pins held at 11
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset sticky", {31'd0, err_sticky}, 32'd0);
    chk("midreset step",   {31'd0, step},       32'd0);
    reset = 1'b0;
    run_vec(mk(2'b11, 2'd0, 20, 0, 0, 1'b1, 0, 1'b0, 1'b0), "reprime");
    run_vec(mk(2'b01, 2'd0, 10, 1, 1, 1'b1, 0, 1'b0, 1'b1), "post01");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
